axis_tx_pkt_buffer: RTL

Store-and-forward AXI4-Stream packet buffer on the Ethernet TX data path, directly upstream of the TX control-stream interface. It accepts frames from the switch core, counts valid bytes per frame, and buffers each complete frame. Per frame, it pushes a 12-bit byte count (`tx_pkt_byte_cnt`/`tx_pkt_byte_cnt_vld`) to the control interface's length FIFO, then releases the frame on `m_axis_txd`. The byte count is therefore always queued before the first data beat of its frame is presented downstream.

---
 rtl/axis_tx_pkt_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axis_tx_pkt_buffer.sv
// Store-and-forward AXI4-Stream TX buffer: counts bytes per frame, releases frames only once complete.
// Latency: byte-count strobe 1 cycle after ingress tlast, earliest egress tvalid 2 cycles after.
// Backpressure: ingress stalls when full with committed frames stored; oversize frames are dropped.
module axis_tx_pkt_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_txd_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_txd_tkeep,
    input  logic                    s_axis_txd_tlast,
    input  logic                    s_axis_txd_tvalid,
    output logic                    s_axis_txd_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_txd_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_txd_tkeep,
    output logic                    m_axis_txd_tlast,
    output logic                    m_axis_txd_tvalid,
    input  logic                    m_axis_txd_tready,
    output logic [11:0]             tx_pkt_byte_cnt,
    output logic                    tx_pkt_byte_cnt_vld,
    output logic                    drop_pulse
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 1 + KW + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

    logic [EW-1:0] mem [DEPTH];

    wr_state_t     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [11:0]   acc_q, acc_d;
    logic [11:0]   cnt_q, cnt_d;
    logic          cnt_vld_q, cnt_vld_d;
    logic          drop_q, drop_d;
    logic [EW-1:0] out_q, out_d;
    logic          out_vld_q, out_vld_d;

    logic          full, wr_en, mem_we, commit, depart, fetch;
    logic [PW-1:0] used, fetch_ptr;
    logic [3:0]    keep_ones;
    logic [12:0]   acc_sum;
    logic [11:0]   acc_sat;

    always_comb begin
        keep_ones = '0;
        for (int i = 0; i < KW; i++) begin
            keep_ones = keep_ones + 4'(s_axis_txd_tkeep[i]);
        end
    end

    assign acc_sum = {1'b0, acc_q} + 13'(keep_ones);
    assign acc_sat = acc_sum[12] ? 12'hFFF : acc_sum[11:0];

    // rd_ptr tracks the beat held in the output register, so that beat still occupies a slot
    assign used  = wr_ptr_q - rd_ptr_q;
    assign full  = (used == PW'(DEPTH));
    assign s_axis_txd_tready = !axis_areset && (!full || state_q == DROP);
    assign wr_en = s_axis_txd_tvalid && s_axis_txd_tready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        cnt_vld_d    = 1'b0;
        drop_d       = 1'b0;
        mem_we       = 1'b0;
        commit       = 1'b0;
        case (state_q)
            IDLE, FILL: begin
                if (state_q == FILL && full && pkt_cnt_q == '0) begin
                    // buffer holds nothing but this frame and it still has no end: it cannot fit
                    state_d  = DROP;
                    wr_ptr_d = commit_ptr_q;
                    acc_d    = '0;
                end else if (wr_en) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_axis_txd_tlast) begin
                        commit       = 1'b1;
                        commit_ptr_d = wr_ptr_q + 1'b1;
                        cnt_d        = acc_sat;
                        cnt_vld_d    = 1'b1;
                        acc_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        acc_d   = acc_sat;
                        state_d = FILL;
                    end
                end
            end
            DROP: begin
                if (wr_en && s_axis_txd_tlast) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_ptr = out_vld_q ? rd_ptr_q + 1'b1 : rd_ptr_q;
        depart    = out_vld_q && m_axis_txd_tready;
        fetch     = (fetch_ptr != commit_ptr_q) && (!out_vld_q || m_axis_txd_tready);
        rd_ptr_d  = rd_ptr_q + PW'(depart);
        out_d     = fetch ? mem[fetch_ptr[AW-1:0]] : out_q;
        out_vld_d = fetch ? 1'b1 : (depart ? 1'b0 : out_vld_q);
        pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(depart && out_q[EW-1]);
    end

    always_ff @(posedge axis_aclk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_txd_tlast, s_axis_txd_tkeep, s_axis_txd_tdata};
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            cnt_vld_q    <= 1'b0;
            drop_q       <= 1'b0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            cnt_vld_q    <= cnt_vld_d;
            drop_q       <= drop_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
        end
    end

    assign m_axis_txd_tdata    = out_q[DATA_WIDTH-1:0];
    assign m_axis_txd_tkeep    = out_q[DATA_WIDTH +: KW];
    assign m_axis_txd_tlast    = out_q[EW-1];
    assign m_axis_txd_tvalid   = out_vld_q;
    assign tx_pkt_byte_cnt     = cnt_q;
    assign tx_pkt_byte_cnt_vld = cnt_vld_q;
    assign drop_pulse          = drop_q;

endmodule
